// File: rtl/nf_bus_pkg.sv
// Shared types and helpers for the nanoFOX data-memory interconnect.
package nf_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } bus_state_e;

  typedef logic [1:0] err_code_t;

  localparam err_code_t ERR_NONE    = 2'b00;
  localparam err_code_t ERR_DECODE  = 2'b01;
  localparam err_code_t ERR_TIMEOUT = 2'b10;

  // Slave-select field width; a single slave still gets a one-bit field.
  function automatic int sel_width(input int slv_n);
    return (slv_n <= 2) ? 1 : $clog2(slv_n);
  endfunction

endpackage

// File: rtl/nf_addr_dec.sv
// Slave-select field extraction, one-hot select and out-of-range flag.
module nf_addr_dec
  import nf_bus_pkg::*;
#(
  parameter  int SLV_N  = 4,
  parameter  int ADDR_W = 32,
  parameter  int SEL_LO = 16,
  localparam int SEL_W  = sel_width(SLV_N)
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [SEL_W-1:0]  idx,
  output logic [SLV_N-1:0]  sel,
  output logic              oor
);

  logic addr_unused;

  assign idx         = addr[SEL_LO +: SEL_W];
  assign addr_unused = ^addr;

  // Only a partially populated select field can address a missing slave.
  if ((1 << SEL_W) > SLV_N) begin : g_oor
    assign oor = (32'(idx) >= 32'(SLV_N));
  end else begin : g_full
    assign oor = 1'b0;
  end

  always_comb begin
    sel = '0;
    for (int i = 0; i < SLV_N; i++) begin
      sel[i] = (32'(idx) == 32'(i));
    end
  end

endmodule

// File: rtl/nf_dm_router.sv
// Data-memory interconnect: registered request forwarding to SLV_N slaves
// with address decode, completion handshake and timeout/decode-error response.
//
// state | meaning
// IDLE  | waiting for req_m; latches request and decodes slave index
// BUSY  | req_s[idx] asserted, waiting for that slave's ack or timeout
// RESP  | one-cycle req_ack_m pulse with rd_m/err_m valid
module nf_dm_router
  import nf_bus_pkg::*;
#(
  parameter int SLV_N   = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int SEL_LO  = 16,
  parameter int TIMEOUT = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ADDR_W-1:0]            addr_m,
  input  logic                         we_m,
  input  logic [DATA_W-1:0]            wd_m,
  input  logic                         req_m,
  output logic [DATA_W-1:0]            rd_m,
  output logic                         req_ack_m,
  output logic                         err_m,
  output logic [ADDR_W-1:0]            addr_s,
  output logic                         we_s,
  output logic [DATA_W-1:0]            wd_s,
  output logic [SLV_N-1:0]             req_s,
  input  logic [SLV_N-1:0][DATA_W-1:0] rd_s,
  input  logic [SLV_N-1:0]             req_ack_s
);

  localparam int SEL_W = sel_width(SLV_N);
  localparam int CNT_W = $clog2(TIMEOUT);

  bus_state_e       state;
  bus_state_e       state_nxt;
  logic [SEL_W-1:0] dec_idx;
  logic [SLV_N-1:0] dec_sel;
  logic             dec_oor;
  logic [SEL_W-1:0] idx_q;
  logic [CNT_W-1:0] tmr;
  logic             tmr_tc;
  err_code_t        err_q;
  logic             slv_ack;
  logic [DATA_W-1:0] slv_rd;

  nf_addr_dec #(
    .SLV_N (SLV_N),
    .ADDR_W(ADDR_W),
    .SEL_LO(SEL_LO)
  ) u_dec (
    .addr(addr_m),
    .idx (dec_idx),
    .sel (dec_sel),
    .oor (dec_oor)
  );

  // Only the latched slave's ack and data are observed.
  always_comb begin
    slv_ack = 1'b0;
    slv_rd  = '0;
    for (int i = 0; i < SLV_N; i++) begin
      if (32'(idx_q) == 32'(i)) begin
        slv_ack = req_ack_s[i];
        slv_rd  = rd_s[i];
      end
    end
  end

  assign tmr_tc = (tmr == '0);
  assign err_m  = |err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_m) state_nxt = dec_oor ? RESP : BUSY;
      BUSY:    if (slv_ack || tmr_tc) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Timer is a down-counter loaded on entry to BUSY; terminal count at zero
  // marks the last BUSY cycle, where a same-cycle ack still wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_m      <= '0;
      req_ack_m <= 1'b0;
      err_q     <= ERR_NONE;
      req_s     <= '0;
      addr_s    <= '0;
      we_s      <= 1'b0;
      wd_s      <= '0;
      tmr       <= '0;
      idx_q     <= '0;
    end else begin
      req_ack_m <= 1'b0;
      case (state)
        IDLE: begin
          if (req_m) begin
            addr_s <= addr_m;
            we_s   <= we_m;
            wd_s   <= wd_m;
            idx_q  <= dec_idx;
            if (dec_oor) begin
              req_ack_m <= 1'b1;
              err_q     <= ERR_DECODE;
            end else begin
              req_s <= dec_sel;
              tmr   <= CNT_W'(TIMEOUT - 1);
            end
          end
        end
        BUSY: begin
          if (slv_ack) begin
            req_s     <= '0;
            req_ack_m <= 1'b1;
            err_q     <= ERR_NONE;
            if (!we_s) rd_m <= slv_rd;
          end else if (tmr_tc) begin
            req_s     <= '0;
            req_ack_m <= 1'b1;
            err_q     <= ERR_TIMEOUT;
            rd_m      <= '0;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        RESP: begin
          tmr <= '0;
        end
        default: begin
          req_s <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/nf_dm_router.md
Name: nf_dm_router

Overview:
Parametrised data-memory interconnect for the nanoFOX core. It sits between the CPU data port (addr_dm/we_dm/wd_dm/rd_dm/req_dm/req_ack_dm) and SLV_N slaves (RAM, GPIO, UART, …). It replaces the tied-high req_ack_dm with a real handshake, per-slave address decode, registered request forwarding, and a timeout/decode-error path.

Parameters:
SLV_N, 4, number of slave ports (1..16)
ADDR_W, 32, address width
DATA_W, 32, data width
SEL_LO, 16, lowest address bit of the slave-select field; field width SEL_W = $clog2(SLV_N) (min 1)
TIMEOUT, 16, cycles in BUSY without slave ack before error response (≥2)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
addr_m  in  ADDR_W  master address
we_m  in  1  master write enable
wd_m  in  DATA_W  master write data
req_m  in  1  master request, held until req_ack_m
rd_m  out  DATA_W  registered read data, valid with req_ack_m
req_ack_m  out  1  one-cycle completion pulse
err_m  out  1  error flag, valid with req_ack_m (decode or timeout)
addr_s  out  ADDR_W  latched address, broadcast to all slaves
we_s  out  1  latched write enable, broadcast
wd_s  out  DATA_W  latched write data, broadcast
req_s  out  SLV_N  one-hot slave request
rd_s  in  SLV_N×DATA_W  packed slave read data, slave i at [i]
req_ack_s  in  SLV_N  slave acknowledges

Behaviour:
- Reset (synchronous, active-high, overrides everything, including mid-transaction): state=IDLE; rd_m=0, req_ack_m=0, err_m=0, req_s=0, addr_s/wd_s=0, we_s=0, timeout counter=0, latched index=0.
- FSM states: IDLE, BUSY, RESP.
- IDLE: if req_m=1, latch addr_m→addr_s, we_m→we_s, wd_m→wd_s, idx=addr_m[SEL_LO +: SEL_W].
  - idx < SLV_N → BUSY.
  - idx ≥ SLV_N (decode error) → RESP with err_m=1 and rd_m unchanged. No slave sees a request.
- BUSY: req_s[idx]=1, all other bits 0; counter increments each cycle.
  - req_ack_s[idx]=1 → RESP, err_m=0; if we_s=0, rd_m←rd_s[idx], otherwise rd_m is held.
  - Else if counter == TIMEOUT-1 → RESP, err_m=1, rd_m←0.
  - An ack in the same cycle the counter expires wins: normal completion.
  - Acks from non-selected slaves are ignored.
- RESP: req_ack_m=1 for exactly this cycle; req_s=0; counter cleared; req_m ignored → IDLE.
  - err_m holds its value until the next RESP or reset.
- Latency: a slave that acks combinationally on its first req_s cycle gives req_m at cycle 0, req_s at cycle 1, req_ack_m at cycle 2. Decode error: req_ack_m at cycle 1.
- Throughput: at most one transaction in flight. Back-to-back requests issue one transaction per 3 cycles.
- Master inputs are sampled only in IDLE; changes during BUSY/RESP have no effect.
- All outputs are registered; there is no combinational path from master inputs to slave outputs.

Decomposition:
- Package nf_bus_pkg holds:
  - the FSM enum (IDLE/BUSY/RESP)
  - the error code constants (ERR_NONE, ERR_DECODE, ERR_TIMEOUT), used internally only; err_m is the OR of the error codes
  - the helper function computing SEL_W from SLV_N
- One sub-module, nf_addr_dec: combinational address-field extraction, one-hot select, and the out-of-range flag; parametrised by SLV_N/ADDR_W/SEL_LO.

Test Plan:
- Read slave 1, addr 0x0001_0010, slave acks immediately with 0xCAFE_F00D -> req_s=4'b0010 at cycle 1 only; addr_s=0x0001_0010; rd_m=0xCAFE_F00D, req_ack_m=1, err_m=0 at cycle 2.
- Write slave 0, addr 0x0000_0004, wd 0x1234_5678, slave ack delayed 3 cycles -> we_s=1, wd_s=0x1234_5678 and req_s=4'b0001 held for 4 cycles; single req_ack_m pulse; rd_m keeps its prior value.
- SLV_N=3, addr 0x0003_0000 -> no req_s bit ever asserts; req_ack_m and err_m both 1 at cycle 1.
- Slave 2 never acks, TIMEOUT=16 -> req_s[2] high for 16 cycles; then req_ack_m=1, err_m=1, rd_m=0. Also: ack on the 16th BUSY cycle -> err_m=0 and data returned.
- Assert reset during BUSY with slave 3 selected -> next cycle req_s=0, req_ack_m=0, rd_m=0, state IDLE; a new request after reset completes normally. A stray req_ack_s[0] during a slave-3 transaction is ignored.
